// File: rtl/epd_tx_arbiter.sv
// epd_tx_arbiter: two-port round-robin transmit arbiter and framer for the
// epd byte link. Prepends preamble/SFD, streams the granted source's frame,
// zero-pads short frames to MIN_FRAME bytes and enforces an IFG_MIN idle gap.
//
// Ports:
//   clock       - rising-edge clock
//   reset       - asynchronous active-low reset
//   req_valid   - per-source byte available
//   req_data    - source i byte on [8i+7:8i]
//   req_last    - per-source final byte marker
//   req_ready   - combinational accept strobe to the granted source
//   tx_data     - registered link byte
//   tx_control  - registered, 1 = data byte, 0 = idle/IFG
//   grant       - registered one-hot owner (or zero)
//   busy        - registered, high outside IDLE
//   frame_count - completed frames, wraps
//   underrun    - one-cycle pulse on mid-frame abort
module epd_tx_arbiter #(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned MIN_FRAME    = 64,
  parameter int unsigned IFG_MIN      = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_data,
  input  logic [1:0]  req_last,
  output logic [1:0]  req_ready,
  output logic [7:0]  tx_data,
  output logic        tx_control,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [3:0]  frame_count,
  output logic        underrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_FRAME, S_PAD, S_IFG
  } state_e;

  localparam logic [7:0] PRE_LAST_C = 8'(PREAMBLE_LEN);
  localparam logic [6:0] MIN_C      = 7'(MIN_FRAME);
  localparam logic [7:0] IFG_C      = 8'(IFG_MIN);

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;
  logic [7:0]  pre_cnt_q, pre_cnt_d;
  logic [6:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  ifg_cnt_q, ifg_cnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_control_q, tx_control_d;
  logic        busy_q, busy_d;
  logic [3:0]  frame_count_q, frame_count_d;
  logic        underrun_q, underrun_d;

  logic [1:0]  arb_grant;
  logic        arb_last;
  logic        start;
  logic        src_valid;
  logic        src_last;
  logic [7:0]  src_byte;
  logic [6:0]  cnt_inc;

  // Round-robin: on a tie the source not granted last time wins.
  always_comb begin
    arb_grant = 2'b00;
    arb_last  = last_q;
    if (req_valid == 2'b01) begin
      arb_grant = 2'b01;
      arb_last  = 1'b0;
    end else if (req_valid == 2'b10) begin
      arb_grant = 2'b10;
      arb_last  = 1'b1;
    end else if (req_valid == 2'b11) begin
      arb_grant = last_q ? 2'b01 : 2'b10;
      arb_last  = ~last_q;
    end
  end

  assign src_valid = |(req_valid & grant_q);
  assign src_last  = |(req_last & grant_q);
  assign src_byte  = grant_q[1] ? req_data[15:8] : req_data[7:0];
  assign cnt_inc   = (byte_cnt_q == 7'h7f) ? 7'h7f : byte_cnt_q + 7'd1;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    pre_cnt_d     = pre_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    ifg_cnt_d     = ifg_cnt_q;
    tx_data_d     = tx_data_q;
    tx_control_d  = tx_control_q;
    frame_count_d = frame_count_q;
    underrun_d    = 1'b0;
    start         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tx_data_d    = 8'h00;
        tx_control_d = 1'b0;
        start        = |req_valid;
      end
      S_PREAMBLE: begin
        tx_control_d = 1'b1;
        if (pre_cnt_q >= PRE_LAST_C) begin
          state_d    = S_SFD;
          tx_data_d  = 8'hd5;
          byte_cnt_d = '0;
        end else begin
          tx_data_d = 8'h55;
          pre_cnt_d = pre_cnt_q + 8'd1;
        end
      end
      S_SFD, S_FRAME: begin
        if (src_valid) begin
          tx_data_d    = src_byte;
          tx_control_d = 1'b1;
          byte_cnt_d   = cnt_inc;
          state_d      = S_FRAME;
          if (src_last) begin
            if (cnt_inc < MIN_C) begin
              state_d = S_PAD;
            end else begin
              // Last byte occupies the first IFG cycle; the idle count starts at 0.
              state_d       = S_IFG;
              ifg_cnt_d     = '0;
              frame_count_d = frame_count_q + 4'd1;
            end
          end
        end else begin
          // Abort: the link goes idle on this edge, so one gap cycle is already spent.
          tx_data_d    = 8'h00;
          tx_control_d = 1'b0;
          underrun_d   = 1'b1;
          state_d      = S_IFG;
          ifg_cnt_d    = 8'd1;
        end
      end
      S_PAD: begin
        tx_data_d    = 8'h00;
        tx_control_d = 1'b1;
        byte_cnt_d   = cnt_inc;
        if (cnt_inc >= MIN_C) begin
          state_d       = S_IFG;
          ifg_cnt_d     = '0;
          frame_count_d = frame_count_q + 4'd1;
        end
      end
      S_IFG: begin
        tx_data_d    = 8'h00;
        tx_control_d = 1'b0;
        if (ifg_cnt_q >= IFG_C) begin
          if (|req_valid) begin
            start = 1'b1;
          end else begin
            state_d = S_IDLE;
            grant_d = 2'b00;
          end
        end else begin
          ifg_cnt_d = ifg_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d      = S_IDLE;
        grant_d      = 2'b00;
        tx_data_d    = 8'h00;
        tx_control_d = 1'b0;
      end
    endcase

    if (start) begin
      state_d      = S_PREAMBLE;
      grant_d      = arb_grant;
      last_d       = arb_last;
      tx_data_d    = 8'h55;
      tx_control_d = 1'b1;
      pre_cnt_d    = 8'd1;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      grant_q       <= 2'b00;
      last_q        <= 1'b1;
      pre_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      ifg_cnt_q     <= '0;
      tx_data_q     <= '0;
      tx_control_q  <= 1'b0;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      pre_cnt_q     <= pre_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      ifg_cnt_q     <= ifg_cnt_d;
      tx_data_q     <= tx_data_d;
      tx_control_q  <= tx_control_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
      underrun_q    <= underrun_d;
    end
  end

  assign req_ready   = (state_q == S_SFD || state_q == S_FRAME) ? grant_q : 2'b00;
  assign tx_data     = tx_data_q;
  assign tx_control  = tx_control_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_epd_tx_arbiter.sv
// Testbench for epd_tx_arbiter: cycle vector table for arbitration, preamble,
// SFD, byte latency and underrun timing, then scoreboarded frame scenarios and
// a second instance with IFG_MIN=3 for the back-to-back wrap case.
module tb_epd_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_last, req_ready, grant;
  logic [15:0] req_data;
  logic [7:0]  tx_data;
  logic        tx_control, busy, underrun;
  logic [3:0]  frame_count;

  logic [1:0]  r3_valid, r3_last, r3_ready, g3;
  logic [15:0] r3_data;
  logic [7:0]  tx3_data;
  logic        tx3_ctrl, busy3, und3;
  logic [3:0]  fc3;

  always #5 clk = ~clk;

  epd_tx_arbiter u_dut (
    .clock(clk), .reset(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_control(tx_control), .grant(grant), .busy(busy),
    .frame_count(frame_count), .underrun(underrun)
  );

  epd_tx_arbiter #(.PREAMBLE_LEN(7), .MIN_FRAME(64), .IFG_MIN(3)) u_dut3 (
    .clock(clk), .reset(rst_n), .req_valid(r3_valid), .req_data(r3_data),
    .req_last(r3_last), .req_ready(r3_ready), .tx_data(tx3_data),
    .tx_control(tx3_ctrl), .grant(g3), .busy(busy3),
    .frame_count(fc3), .underrun(und3)
  );

  typedef struct {
    logic [1:0]  v;
    logic [15:0] d;
    logic [1:0]  l;
    logic [7:0]  e_data;
    logic        e_ctrl;
    logic [1:0]  e_grant;
    logic [1:0]  e_ready;
    logic        e_busy;
    logic        e_und;
  } vec_t;

  vec_t tbl[21];

  int tests = 0;
  int fails = 0;

  // Source models and link scoreboard
  logic [8:0] sq0[$];
  logic [8:0] sq1[$];
  logic [7:0] pay_q[$];
  logic [7:0] exp_q[$];
  int exp_len_q[$];
  int exp_port_q[$];
  int exp_gap_q[$];
  bit auto_drv, mon_en, in_burst;
  int burst_len, burst_err, cur_len, cur_port, gap_cnt, und_cnt;

  // Second instance: port 0 streams 64-byte frames back to back
  int f3_left = 0, idx3 = 0;
  bit mon3_en, in3;
  int len3, gap3, bursts3, len_bad3, gap_bad3, gaps3;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic drive();
    req_valid = {sq1.size() != 0, sq0.size() != 0};
    req_data  = {(sq1.size() != 0) ? sq1[0][7:0] : 8'h00,
                 (sq0.size() != 0) ? sq0[0][7:0] : 8'h00};
    req_last  = {(sq1.size() != 0) ? sq1[0][8] : 1'b0,
                 (sq0.size() != 0) ? sq0[0][8] : 1'b0};
  endtask

  task automatic drive3();
    r3_valid = {1'b0, f3_left > 0};
    r3_data  = {8'h00, 8'(idx3 + 32'h40)};
    r3_last  = {1'b0, idx3 == 63};
  endtask

  task automatic monitor();
    logic [7:0] b;
    if (!mon_en) return;
    if (underrun) und_cnt++;
    if (tx_control) begin
      if (!in_burst) begin
        in_burst  = 1'b1;
        burst_len = 0;
        burst_err = 0;
        if (exp_len_q.size() == 0) begin
          cur_len  = 0;
          cur_port = 0;
        end else begin
          int g;
          cur_len  = exp_len_q.pop_front();
          cur_port = exp_port_q.pop_front();
          g        = exp_gap_q.pop_front();
          if (g >= 0) check("ifg_gap", 64'(gap_cnt), 64'(g));
        end
      end
      burst_len++;
      if (burst_len <= cur_len) begin
        b = exp_q.pop_front();
        if (tx_data !== b) burst_err++;
      end
      if (grant !== ((cur_port == 1) ? 2'b10 : 2'b01)) burst_err++;
    end else begin
      if (in_burst) begin
        in_burst = 1'b0;
        for (int k = burst_len; k < cur_len; k++) void'(exp_q.pop_front());
        tests++;
        if (burst_len != cur_len || burst_err != 0) begin
          fails++;
          $display("FAIL burst: len %0d want %0d, byte/grant errors %0d want 0",
                   burst_len, cur_len, burst_err);
        end
        gap_cnt = 1;
      end else begin
        gap_cnt++;
      end
    end
  endtask

  task automatic monitor3();
    if (!mon3_en) return;
    if (tx3_ctrl) begin
      if (!in3) begin
        in3  = 1'b1;
        len3 = 0;
        if (bursts3 > 0) begin
          gaps3++;
          if (gap3 != 3) gap_bad3++;
        end
      end
      len3++;
    end else if (in3) begin
      in3 = 1'b0;
      bursts3++;
      if (len3 != 72) len_bad3++;
      gap3 = 1;
    end else begin
      gap3++;
    end
  endtask

  task automatic step();
    bit a0, a1, a3;
    @(negedge clk);
    a0 = req_valid[0] && req_ready[0];
    a1 = req_valid[1] && req_ready[1];
    a3 = r3_valid[0] && r3_ready[0];
    @(posedge clk);
    #1;
    monitor();
    monitor3();
    if (auto_drv) begin
      if (a0 && sq0.size() != 0) void'(sq0.pop_front());
      if (a1 && sq1.size() != 0) void'(sq1.pop_front());
      drive();
    end
    if (a3) begin
      idx3++;
      if (idx3 == 64) begin
        idx3 = 0;
        f3_left--;
      end
    end
    drive3();
  endtask

  task automatic fill_pay(input int n, input logic [7:0] seed);
    for (int k = 0; k < n; k++) pay_q.push_back(8'(seed + 8'(k)));
  endtask

  // Queues pay_q for a source and the matching link burst for the scoreboard.
  task automatic add_frame(input int port, input bit complete, input int gap);
    int n;
    n = pay_q.size();
    for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hd5);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(pay_q[k]);
      if (port == 0) sq0.push_back({complete && (k == n - 1), pay_q[k]});
      else           sq1.push_back({complete && (k == n - 1), pay_q[k]});
    end
    if (complete) for (int k = n; k < 64; k++) exp_q.push_back(8'h00);
    exp_len_q.push_back(8 + ((complete && n < 64) ? 64 : n));
    exp_port_q.push_back(port);
    exp_gap_q.push_back(gap);
    pay_q.delete();
  endtask

  task automatic run_idle(input string name, input int budget);
    int c;
    c = 0;
    do begin
      step();
      c++;
    end while ((sq0.size() != 0 || sq1.size() != 0 || busy || in_burst) && c < budget);
    check({name, "_idle"}, {63'd0, busy}, 64'd0);
    check({name, "_drained"}, 64'(exp_len_q.size()), 64'd0);
  endtask

  task automatic fill_table();
    tbl[0] = '{2'b00, 16'h0000, 2'b00, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    for (int i = 1; i <= 7; i++)
      tbl[i] = '{2'b11, 16'hb1a1, 2'b00, 8'h55, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0};
    tbl[8]  = '{2'b11, 16'hb1a1, 2'b00, 8'hd5, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0};
    tbl[9]  = '{2'b11, 16'hb111, 2'b00, 8'h11, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0};
    tbl[10] = '{2'b11, 16'hb122, 2'b00, 8'h22, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0};
    tbl[11] = '{2'b10, 16'hb100, 2'b00, 8'h00, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1};
    for (int i = 12; i <= 18; i++)
      tbl[i] = '{2'b10, 16'hb100, 2'b00, 8'h55, 1'b1, 2'b10, 2'b00, 1'b1, 1'b0};
    tbl[19] = '{2'b10, 16'hb100, 2'b00, 8'hd5, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0};
    tbl[20] = '{2'b10, 16'hc300, 2'b10, 8'hc3, 1'b1, 2'b10, 2'b00, 1'b1, 1'b0};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pads, other, c, und0;
    rst_n = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    auto_drv = 1'b0; mon_en = 1'b0; mon3_en = 1'b0;
    drive3();
    fill_table();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {tx_data, tx_control, grant, busy, frame_count, underrun, req_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Cycle vectors: tie to port 0, preamble, SFD, bytes, underrun, port 1 after IFG
    foreach (tbl[i]) begin
      req_valid = tbl[i].v;
      req_data  = tbl[i].d;
      req_last  = tbl[i].l;
      step();
      check($sformatf("vec%0d", i),
            {tx_data, tx_control, grant, req_ready, busy, underrun},
            {tbl[i].e_data, tbl[i].e_ctrl, tbl[i].e_grant, tbl[i].e_ready, tbl[i].e_busy, tbl[i].e_und});
    end

    // 1-byte frame: 63 pad bytes, frame_count visible on the first idle cycle
    req_valid = '0; req_data = '0; req_last = '0;
    pads = 0; other = 0; c = 0;
    do begin
      step();
      c++;
      if (tx_control && tx_data == 8'h00) pads++;
      else if (tx_control) other++;
    end while (tx_control && c < 200);
    check("pad_count", 64'(pads), 64'd63);
    check("pad_other", 64'(other), 64'd0);
    check("pad_fc", {60'd0, frame_count}, 64'd1);
    c = 0;
    while (busy && c < 10) begin
      step();
      c++;
    end
    check("pad_release", {62'd0, grant}, 64'd0);

    auto_drv = 1'b1;
    mon_en   = 1'b1;
    gap_cnt  = 0;
    und_cnt  = 0;

    // Single valid frame on port 0
    for (int k = 0; k < 6; k++) pay_q.push_back(8'(k + 1));
    for (int k = 0; k < 6; k++) pay_q.push_back(8'(8'hff - 8'(k)));
    pay_q.push_back(8'h08);
    pay_q.push_back(8'h00);
    for (int k = 0; k < 49; k++) pay_q.push_back(8'h55);
    pay_q.push_back(8'hff);
    add_frame(0, 1'b1, -1);
    run_idle("single", 300);
    check("single_fc", {60'd0, frame_count}, 64'd2);

    // Short frame on port 1
    fill_pay(20, 8'ha0);
    add_frame(1, 1'b1, -1);
    run_idle("short", 300);
    check("short_fc", {60'd0, frame_count}, 64'd3);

    // Contention: grants 0,1,0,1 with one idle cycle between frames
    fill_pay(64, 8'h10); add_frame(0, 1'b1, -1);
    fill_pay(64, 8'h80); add_frame(1, 1'b1, 1);
    fill_pay(64, 8'h20); add_frame(0, 1'b1, 1);
    fill_pay(64, 8'h90); add_frame(1, 1'b1, 1);
    run_idle("contend", 800);
    check("contend_fc", {60'd0, frame_count}, 64'd7);

    // Underrun after 30 bytes on port 0, port 1 pending behind it
    und0 = und_cnt;
    fill_pay(30, 8'h40);
    add_frame(0, 1'b0, -1);
    step();
    step();
    fill_pay(64, 8'hc0);
    add_frame(1, 1'b1, 1);
    run_idle("underrun", 500);
    check("underrun_pulses", 64'(und_cnt - und0), 64'd1);
    check("underrun_fc", {60'd0, frame_count}, 64'd8);

    // Asynchronous reset in mid-frame, then tie goes to port 0 again
    fill_pay(64, 8'h30);
    add_frame(0, 1'b1, -1);
    repeat (20) step();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", {tx_data, tx_control, grant, busy, frame_count, underrun, req_ready}, 64'd0);
    mon_en = 1'b0;
    sq0.delete(); sq1.delete(); exp_q.delete();
    exp_len_q.delete(); exp_port_q.delete(); exp_gap_q.delete();
    in_burst = 1'b0;
    drive();
    step();
    check("reset_hold", {tx_data, tx_control, grant, busy, frame_count, underrun, req_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    gap_cnt = 0;
    fill_pay(64, 8'h70); add_frame(0, 1'b1, -1);
    fill_pay(64, 8'he0); add_frame(1, 1'b1, 1);
    run_idle("post_reset", 500);
    check("post_reset_fc", {60'd0, frame_count}, 64'd2);

    // IFG_MIN=3: 17 back-to-back frames, frame_count wraps to 1
    mon3_en = 1'b1;
    gap3 = 0; bursts3 = 0; len_bad3 = 0; gap_bad3 = 0; gaps3 = 0;
    f3_left = 17;
    drive3();
    c = 0;
    do begin
      step();
      c++;
    end while ((f3_left > 0 || busy3 || in3) && c < 3000);
    check("ifg3_bursts", 64'(bursts3), 64'd17);
    check("ifg3_len_bad", 64'(len_bad3), 64'd0);
    check("ifg3_gaps", 64'(gaps3), 64'd16);
    check("ifg3_gap_bad", 64'(gap_bad3), 64'd0);
    check("ifg3_fc", {60'd0, fc3}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
